// File: rtl/gpio_mbx_responder.sv
// GPIO mailbox responder: decodes CPU commands over a 4-phase REQ/ACK handshake
// and serves a bank of control registers and status inputs. Optional watchdog: MBX_WDOG_EN.
module gpio_mbx_responder #(
    parameter int unsigned NREGS       = 8,
    parameter int unsigned NSTAT       = 4,
    parameter int unsigned WDOG_CYCLES = 1000000
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [31:0]           mbx_w_i,
    input  logic [31:0]           mbx_s_i,
    output logic [31:0]           mbx_r_o,
    output logic [NREGS*32-1:0]   ctrl_q_o,
    output logic [NREGS-1:0]      ctrl_wr_stb_o,
    input  logic [NSTAT*32-1:0]   stat_i,
    output logic                  wdog_trip_o
);

    localparam int unsigned DW = 32;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_RD_LO = 3'd2;
    localparam logic [2:0] OP_RD_HI = 3'd3;
    localparam logic [2:0] OP_SET   = 3'd4;
    localparam logic [2:0] OP_CLR   = 3'd5;

    typedef enum logic [1:0] {IDLE, EXEC, ACK, WAIT_LOW} state_t;

    state_t              state_q, state_d;
    logic                req_q;
    logic [DW-1:0]       cmd_q, cmd_d;
    logic [2:0]          op_q, op_d;
    logic [7:0]          addr_q, addr_d;
    logic [DW-1:0]       resp_q, resp_d;
    logic [DW-1:0]       regs_q [NREGS];
    logic [DW-1:0]       regs_d [NREGS];
    logic [NREGS-1:0]    stb_q, stb_d;
    logic                reg_hit, stat_hit, err, wr_ok;
    logic [DW-1:0]       src, wr_val;
    logic [15:0]         data;

`ifdef MBX_WDOG_EN
    localparam int unsigned WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          trip_q, trip_d;
`endif

    // Only REQ, OPCODE and ADDR of the control word are meaningful
    logic unused_ctl;
    assign unused_ctl = ^{mbx_s_i[31:16], mbx_s_i[7:4]};

    // Address decode and read source select
    always_comb begin
        reg_hit  = 1'b0;
        stat_hit = 1'b0;
        src      = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (addr_q == 8'(k)) begin
                reg_hit = 1'b1;
                src     = regs_q[k];
            end
        end
        for (int j = 0; j < NSTAT; j++) begin
            if (addr_q == 8'(128 + j)) begin
                stat_hit = 1'b1;
                src      = stat_i[32*j +: 32];
            end
        end
    end

    // Next-state, response, register file and strobe logic
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op_d    = op_q;
        addr_d  = addr_q;
        resp_d  = resp_q;
        regs_d  = regs_q;
        stb_d   = '0;
        err     = 1'b0;
        wr_ok   = 1'b0;
        wr_val  = '0;
        data    = '0;
`ifdef MBX_WDOG_EN
        wdog_d  = wdog_q + WW'(1);
        trip_d  = trip_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_q) begin
                    cmd_d   = mbx_w_i;
                    op_d    = mbx_s_i[3:1];
                    addr_d  = mbx_s_i[15:8];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_NOP: ;
                    OP_WRITE, OP_SET, OP_CLR: begin
                        wr_ok = reg_hit;
                        err   = !reg_hit;
                    end
                    OP_RD_LO: begin
                        err  = !(reg_hit || stat_hit);
                        data = err ? 16'h0 : src[15:0];
                    end
                    OP_RD_HI: begin
                        err  = !(reg_hit || stat_hit);
                        data = err ? 16'h0 : src[31:16];
                    end
                    default: err = 1'b1;
                endcase
                case (op_q)
                    OP_SET:  wr_val = src | cmd_q;
                    OP_CLR:  wr_val = src & ~cmd_q;
                    default: wr_val = cmd_q;
                endcase
                for (int k = 0; k < NREGS; k++) begin
                    if (wr_ok && addr_q == 8'(k)) begin
                        regs_d[k] = wr_val;
                        stb_d[k]  = 1'b1;
                    end
                end
                resp_d  = {1'b1, err, op_q, 11'h0, data};
                state_d = ACK;
            end
            ACK: begin
                // REQ already gone: ACK has been shown for its one cycle, finish now
                if (req_q) begin
                    state_d = WAIT_LOW;
                end else begin
                    resp_d  = '0;
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!req_q) begin
                    resp_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MBX_WDOG_EN
        // Reaching ACK beats a simultaneous timeout
        if (state_q == EXEC) begin
            wdog_d = '0;
            trip_d = 1'b0;
        end else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
            wdog_d = '0;
            trip_d = 1'b1;
            for (int k = 0; k < NREGS; k++) regs_d[k] = '0;
        end
`endif
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            cmd_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            resp_q  <= '0;
            regs_q  <= '{default: '0};
            stb_q   <= '0;
`ifdef MBX_WDOG_EN
            wdog_q  <= '0;
            trip_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= mbx_s_i[0];
            cmd_q   <= cmd_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            resp_q  <= resp_d;
            regs_q  <= regs_d;
            stb_q   <= stb_d;
`ifdef MBX_WDOG_EN
            wdog_q  <= wdog_d;
            trip_q  <= trip_d;
`endif
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_ctrl
        assign ctrl_q_o[32*k +: 32] = regs_q[k];
    end

    assign mbx_r_o       = resp_q;
    assign ctrl_wr_stb_o = stb_q;

`ifdef MBX_WDOG_EN
    assign wdog_trip_o = trip_q;
`else
    logic unused_wdog;
    assign unused_wdog = |32'(WDOG_CYCLES);
    assign wdog_trip_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_mbx_responder.sv
// Directed bench for gpio_mbx_responder: register/status access, errors, handshake timing,
// async reset and (when MBX_WDOG_EN is defined) the watchdog.
module tb_gpio_mbx_responder;

    localparam int unsigned NREGS = 8;
    localparam int unsigned NSTAT = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [31:0]          mbx_w_i, mbx_s_i, mbx_r_o;
    logic [NREGS*32-1:0]  ctrl_q_o;
    logic [NREGS-1:0]     ctrl_wr_stb_o;
    logic [NSTAT*32-1:0]  stat_i;
    logic                 wdog_trip_o;

    logic [31:0] exp_regs [NREGS];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gpio_mbx_responder #(.NREGS(NREGS), .NSTAT(NSTAT), .WDOG_CYCLES(16)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .mbx_w_i       (mbx_w_i),
        .mbx_s_i       (mbx_s_i),
        .mbx_r_o       (mbx_r_o),
        .ctrl_q_o      (ctrl_q_o),
        .ctrl_wr_stb_o (ctrl_wr_stb_o),
        .stat_i        (stat_i),
        .wdog_trip_o   (wdog_trip_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < NREGS; k++)
            check($sformatf("%s_reg%0d", tag, k), ctrl_q_o[32*k +: 32], exp_regs[k]);
    endtask

    task automatic set_req(input logic [2:0] op, input logic [7:0] a, input logic [31:0] w,
                           input logic req);
        mbx_w_i = w;
        mbx_s_i = {16'h0, a, 4'h0, op, req};
    endtask

    // Full transaction; returns response and strobe seen in the first ACK cycle
    task automatic txn(input logic [2:0] op, input logic [7:0] a, input logic [31:0] w,
                       output logic [31:0] resp, output logic [7:0] stb);
        int n;
        @(negedge clk);
        set_req(op, a, w, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mbx_r_o[31] && n < 20);
        if (!mbx_r_o[31]) check("ack_timeout", mbx_r_o, 32'h8000_0000);
        resp = mbx_r_o;
        stb  = ctrl_wr_stb_o;
        mbx_s_i[0] = 1'b0;
        n = 0;
        while (mbx_r_o != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (mbx_r_o != 0) check("clear_timeout", mbx_r_o, 32'h0);
        check("stb_after", 32'(ctrl_wr_stb_o), 32'h0);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [31:0] w, input logic [31:0] exp_resp, input logic [7:0] exp_stb);
        logic [31:0] resp;
        logic [7:0]  stb;
        txn(op, a, w, resp, stb);
        check(tag, resp, exp_resp);
        check({tag, "_stb"}, 32'(stb), 32'(exp_stb));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat, pulses;
        rst_n   = 1'b0;
        mbx_w_i = '0;
        mbx_s_i = '0;
        stat_i  = {32'hCAFE_0003, 32'h0BAD_0002, 32'h1234_5678, 32'h55AA_0000};
        for (int k = 0; k < NREGS; k++) exp_regs[k] = '0;

        repeat (3) @(negedge clk);
        check("rst_resp", mbx_r_o, 32'h0);
        check("rst_stb", 32'(ctrl_wr_stb_o), 32'h0);
        check("rst_trip", 32'(wdog_trip_o), 32'h0);
        check_regs("rst");
        rst_n = 1'b1;

        // Write then read back
        run("wr2", 3'd1, 8'd2, 32'hDEAD_BEEF, 32'h8800_0000, 8'h04);
        exp_regs[2] = 32'hDEAD_BEEF;
        check_regs("wr2");
        run("rdlo2", 3'd2, 8'd2, 32'h0, 32'h9000_BEEF, 8'h00);
        run("rdhi2", 3'd3, 8'd2, 32'h0, 32'h9800_DEAD, 8'h00);

        // SET / CLR
        run("wr3", 3'd1, 8'd3, 32'h0000_FF00, 32'h8800_0000, 8'h08);
        run("set3", 3'd4, 8'd3, 32'h0000_00F0, 32'hA000_0000, 8'h08);
        check("set3_val", ctrl_q_o[96 +: 32], 32'h0000_FFF0);
        run("clr3", 3'd5, 8'd3, 32'h0000_F000, 32'hA800_0000, 8'h08);
        check("clr3_val", ctrl_q_o[96 +: 32], 32'h0000_0FF0);
        exp_regs[3] = 32'h0000_0FF0;
        run("rdlo3", 3'd2, 8'd3, 32'h0, 32'h9000_0FF0, 8'h00);

        // Status inputs
        run("stlo1", 3'd2, 8'h81, 32'h0, 32'h9000_5678, 8'h00);
        run("sthi3", 3'd3, 8'h83, 32'h0, 32'h9800_CAFE, 8'h00);
        run("wrstat", 3'd1, 8'h81, 32'hFFFF_FFFF, 32'hC800_0000, 8'h00);
        check_regs("wrstat");

        // Errors and boundaries
        run("op6", 3'd6, 8'd0, 32'h0, 32'hF000_0000, 8'h00);
        run("op7", 3'd7, 8'd2, 32'h1, 32'hF800_0000, 8'h00);
        run("rd40", 3'd2, 8'h40, 32'h0, 32'hD000_0000, 8'h00);
        run("rd84", 3'd2, 8'h84, 32'h0, 32'hD000_0000, 8'h00);
        run("wr8", 3'd1, 8'd8, 32'h1111_1111, 32'hC800_0000, 8'h00);
        run("set80", 3'd4, 8'h80, 32'h1, 32'hE000_0000, 8'h00);
        run("nop", 3'd0, 8'd3, 32'hFFFF, 32'h8000_0000, 8'h00);
        run("wr7", 3'd1, 8'd7, 32'h1357_9BDF, 32'h8800_0000, 8'h80);
        exp_regs[7] = 32'h1357_9BDF;
        check_regs("errs");

        // Latency and REQ held high: one transaction only
        @(negedge clk);
        set_req(3'd1, 8'd5, 32'h1111_2222, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mbx_r_o[31] && lat < 20);
        check("ack_latency", 32'(lat), 32'd3);
        pulses = (ctrl_wr_stb_o != 0) ? 1 : 0;
        repeat (6) begin
            @(negedge clk);
            if (ctrl_wr_stb_o != 0) pulses++;
        end
        check("hold_pulses", 32'(pulses), 32'd1);
        check("hold_ack", mbx_r_o, 32'h8800_0000);
        mbx_s_i[0] = 1'b0;
        @(negedge clk);
        check("clr_edge1", mbx_r_o, 32'h8800_0000);
        @(negedge clk);
        check("clr_edge2", mbx_r_o, 32'h0);
        exp_regs[5] = 32'h1111_2222;

        // REQ drops during EXEC
        @(negedge clk);
        set_req(3'd1, 8'd6, 32'hA5A5_A5A5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        mbx_s_i[0] = 1'b0;
        check("exec_pre", mbx_r_o, 32'h0);
        @(negedge clk);
        check("exec_ack", mbx_r_o, 32'h8800_0000);
        check("exec_stb", 32'(ctrl_wr_stb_o), 32'h40);
        @(negedge clk);
        check("exec_clr", mbx_r_o, 32'h0);
        @(negedge clk);
        check("exec_idle", mbx_r_o, 32'h0);
        exp_regs[6] = 32'hA5A5_A5A5;
        check_regs("exec");

        // Async reset while waiting for REQ low
        @(negedge clk);
        set_req(3'd2, 8'd2, 32'h0, 1'b1);
        repeat (4) @(negedge clk);
        check("wl_resp", mbx_r_o, 32'h9000_BEEF);
        #2 rst_n = 1'b0;
        #1;
        check("arst_resp", mbx_r_o, 32'h0);
        for (int k = 0; k < NREGS; k++) exp_regs[k] = '0;
        check_regs("arst");
        mbx_s_i = '0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MBX_WDOG_EN
        run("wd_wr", 3'd1, 8'd1, 32'hFFFF_0000, 32'h8800_0000, 8'h02);
        @(negedge clk);
        set_req(3'd0, 8'd0, 32'h0, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mbx_r_o[31] && lat < 20);
        mbx_s_i[0] = 1'b0;
        lat = 0;
        pulses = 0;
        while (!wdog_trip_o && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ctrl_wr_stb_o != 0) pulses++;
        end
        check("wd_cycles", 32'(lat), 32'd16);
        check("wd_trip", 32'(wdog_trip_o), 32'h1);
        check("wd_nostb", 32'(pulses), 32'd0);
        check_regs("wd_clear");
        run("wd_nop", 3'd0, 8'd0, 32'h0, 32'h8000_0000, 8'h00);
        check("wd_untrip", 32'(wdog_trip_o), 32'h0);
        run("wd_wr4", 3'd1, 8'd4, 32'h0000_00C3, 32'h8800_0000, 8'h10);
        exp_regs[4] = 32'h0000_00C3;
        for (int i = 0; i < 5; i++) begin
            repeat (3) @(negedge clk);
            run("wd_keep", 3'd2, 8'd4, 32'h0, 32'h9000_00C3, 8'h00);
            check("wd_notrip", 32'(wdog_trip_o), 32'h0);
        end
        check_regs("wd_keep");
`else
        repeat (20) @(negedge clk);
        check("trip_off", 32'(wdog_trip_o), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gpio_mbx_responder.md
Name: gpio_mbx_responder

Overview:
- Fabric-side responder for the CPU's GPIO mailbox channel.
- The PULPino core drives a command word and a strobe/control word through two output PIOs, and reads the response through one input PIO.
- This block decodes each command with a 4-phase REQ/ACK handshake, then either updates a bank of control registers (ECU actuator settings) or returns status inputs (ECU sensors).
- One instance serves one channel, e.g. the gpio_a_w / gpio_a_s / gpio_a_r triple.

Parameters:
- NREGS, 8, number of 32-bit read/write control registers (1..128).
- NSTAT, 4, number of 32-bit read-only status inputs (1..128).
- WDOG_CYCLES, 1000000, watchdog timeout in clk_clk cycles (used only with the optional feature).

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  reset; asynchronous assert, active-low.
- mbx_w_i  in  32  command data word (from the CPU write PIO).
- mbx_s_i  in  32  control word (from the CPU strobe PIO): bit0 REQ; bits[3:1] OPCODE; bits[15:8] ADDR; other bits ignored.
- mbx_r_o  out  32  response word (to the CPU read PIO): bit31 ACK; bit30 ERR; bits[29:27] echoed OPCODE; bits[15:0] DATA; other bits 0.
- ctrl_q_o  out  NREGS*32  flattened control registers; register k is at bits [32k+31:32k].
- ctrl_wr_stb_o  out  NREGS  one-cycle pulse on bit k when register k is modified.
- stat_i  in  NSTAT*32  flattened status inputs.
- wdog_trip_o  out  1  watchdog tripped flag.

Behaviour:
- Reset (async, active-low): all outputs 0, all control registers 0, FSM in IDLE, watchdog counter 0.
- REQ is registered once into req_q. mbx_w_i and mbx_s_i are captured in the same cycle the FSM leaves IDLE.
- FSM states: IDLE, EXEC, ACK, WAIT_LOW.
  - IDLE: on req_q=1, capture cmd/ctl and go to EXEC.
  - EXEC: perform the operation, load the response register, go to ACK.
  - ACK: mbx_r_o[31]=1; go to WAIT_LOW. ACK is always held for at least this one cycle.
  - WAIT_LOW: hold the response while req_q=1. On req_q=0, clear mbx_r_o to 0 and return to IDLE.
- Latency: ACK appears at mbx_r_o on the 3rd rising edge after REQ rises at the port. ACK clears on the 2nd edge after REQ falls.
- REQ falling during EXEC: the operation still completes, ACK is still shown for one cycle, then everything clears.
- A new REQ rise is accepted only from IDLE. REQ held high after clear does not start a second transaction; REQ must go low and then high again.
- Opcodes (A = ADDR):
  - 0 NOP: DATA=0.
  - 1 WRITE: if A<NREGS, reg[A] <= mbx_w_i.
  - 2 READ_LO: DATA = bits[15:0] of the source.
  - 3 READ_HI: DATA = bits[31:16] of the source.
  - 4 SET: if A<NREGS, reg[A] <= reg[A] | mbx_w_i.
  - 5 CLR: if A<NREGS, reg[A] <= reg[A] & ~mbx_w_i.
  - 6 and 7: illegal, ERR=1.
- Read source: reg[A] for A<NREGS; stat_i word (A-0x80) for 0x80<=A<0x80+NSTAT.
- Any other address, or opcode 1/4/5 with A>=0x80, gives ERR=1, DATA=0, and no state change.
- On error the response still completes the handshake normally.
- ctrl_wr_stb_o[A] pulses in the cycle after EXEC only for a successful WRITE/SET/CLR. It pulses even if the value is unchanged.
- A register updated in EXEC is visible on ctrl_q_o on the next cycle. A READ in the following transaction returns the new value.

Optional Feature:
- Macro MBX_WDOG_EN.
- Defined:
  - A counter increments every cycle and resets to 0 when any transaction reaches ACK, error or not.
  - When the counter reaches WDOG_CYCLES-1, wdog_trip_o is set and all control registers are cleared to 0 (failsafe actuator state). No strobes are issued for this clear.
  - wdog_trip_o stays set until the next completed transaction, which clears it in the ACK cycle.
  - A trip coinciding with ACK: ACK wins, so the counter resets and no clear occurs.
- Not defined: no counter; wdog_trip_o is tied to 0.

Test Plan:
- Write then read: WRITE A=2, w=0xDEADBEEF -> ctrl_q_o word2=0xDEADBEEF, ctrl_wr_stb_o=0x04 for one cycle. READ_LO A=2 -> mbx_r_o=0x9000BEEF. READ_HI -> 0x9800DEAD.
- SET/CLR: reg3=0x0000FF00; SET w=0x000000F0 -> 0x0000FFF0; CLR w=0x0000F000 -> 0x00000FF0; READ_LO -> DATA=0x0FF0.
- Status read: stat_i word1=0x12345678; READ_LO A=0x81 -> DATA=0x5678, ERR=0. WRITE A=0x81 -> ERR=1 (mbx_r_o=0xC8000000), stat_i and registers unaffected.
- Errors: opcode 6 -> mbx_r_o=0xF0000000. READ A=0x40 with NREGS=8 -> ERR=1.
- Handshake timing: REQ rise at edge t -> ACK at t+3. REQ held 10 cycles -> a single transaction. REQ drop during EXEC -> ACK for exactly 1 cycle, then 0. Assert reset_reset_n=0 in WAIT_LOW -> mbx_r_o=0 immediately, registers 0.
- MBX_WDOG_EN with WDOG_CYCLES=16: no transactions -> wdog_trip_o=1 at cycle 16, registers cleared. Next NOP -> wdog_trip_o=0. Transactions every 10 cycles -> no trip.
